// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for the 100-floors game.
// Owns run state, lives, hit cooldown, speed ramp and frame strobe.
module game_flow_ctrl #(
    parameter int LIVES          = 4,
    parameter int HIT_COOLDOWN   = 30,
    parameter int VBLANK_LINE    = 600,
    parameter int SPEED_STEP_SEC = 10,
    parameter int MAX_SPEED      = 7
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause,
    input  logic [9:0] vector_y,
    input  logic       sec_tick,
    input  logic       hit_spike,
    input  logic       fell_off,
    input  logic       heal,
    output logic [1:0] state,
    output logic       frame_en,
    output logic [2:0] scroll_speed,
    output logic [2:0] lives,
    output logic       invuln,
    output logic       endgame,
    output logic [1:0] sound_req
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [5:0] COOL_INIT  = 6'(HIT_COOLDOWN);
    localparam logic [9:0] VB_LINE    = 10'(VBLANK_LINE);
    localparam logic [7:0] SEC_LAST   = 8'(SPEED_STEP_SEC - 1);
    localparam logic [2:0] SPEED_MAX  = 3'(MAX_SPEED);

    localparam logic [1:0] SND_NONE = 2'd0;
    localparam logic [1:0] SND_HIT  = 2'd1;
    localparam logic [1:0] SND_HEAL = 2'd2;
    localparam logic [1:0] SND_OVER = 2'd3;

    state_t      state_q;
    logic        start_d;
    logic [9:0]  vy_d;
    logic [5:0]  cooldown;
    logic [7:0]  sec_cnt;

    logic        start_rise;
    logic        vblank_edge;
    logic        hit_ok;
    logic        heal_ok;

    assign state       = state_q;
    assign start_rise  = start_btn & ~start_d;
    assign vblank_edge = (vector_y == VB_LINE) && (vy_d != VB_LINE);
    assign hit_ok      = hit_spike & ~invuln;
    assign heal_ok     = heal && (lives < LIVES_INIT);

    // History registers for start-button edge and scan-line change detect
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            start_d <= 1'b0;
            vy_d    <= 10'd0;
        end else begin
            start_d <= start_btn;
            vy_d    <= vector_y;
        end
    end

    // Main game-flow state machine with registered outputs
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lives        <= LIVES_INIT;
            scroll_speed <= 3'd1;
            invuln       <= 1'b0;
            cooldown     <= 6'd0;
            sec_cnt      <= 8'd0;
            endgame      <= 1'b0;
            frame_en     <= 1'b0;
            sound_req    <= SND_NONE;
        end else begin
            sound_req <= SND_NONE;
            frame_en  <= vblank_edge && (state_q == S_RUN);

            unique case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Cooldown counts frames, not clock cycles
                    if (frame_en && (cooldown != 6'd0)) begin
                        cooldown <= cooldown - 6'd1;
                        invuln   <= (cooldown != 6'd1);
                    end

                    // Difficulty ramp on whole seconds of play
                    if (sec_tick) begin
                        if (sec_cnt == SEC_LAST) begin
                            sec_cnt <= 8'd0;
                            if (scroll_speed < SPEED_MAX) begin
                                scroll_speed <= scroll_speed + 3'd1;
                            end
                        end else begin
                            sec_cnt <= sec_cnt + 8'd1;
                        end
                    end

                    if (fell_off) begin
                        lives     <= 3'd0;
                        state_q   <= S_OVER;
                        endgame   <= 1'b1;
                        sound_req <= SND_OVER;
                    end else if (pause) begin
                        state_q <= S_PAUSED;
                    end else if (hit_ok) begin
                        if (lives == 3'd1) begin
                            lives     <= 3'd0;
                            state_q   <= S_OVER;
                            endgame   <= 1'b1;
                            sound_req <= SND_OVER;
                        end else begin
                            lives     <= lives - 3'd1;
                            cooldown  <= COOL_INIT;
                            invuln    <= 1'b1;
                            sound_req <= SND_HIT;
                        end
                    end else if (heal_ok) begin
                        lives     <= lives + 3'd1;
                        sound_req <= SND_HEAL;
                    end
                end

                S_PAUSED: begin
                    if (!pause) begin
                        state_q <= S_RUN;
                    end
                end

                S_OVER: begin
                    // Back to a fresh game; a new press is needed to run
                    if (start_rise) begin
                        state_q      <= S_IDLE;
                        lives        <= LIVES_INIT;
                        scroll_speed <= 3'd1;
                        invuln       <= 1'b0;
                        cooldown     <= 6'd0;
                        sec_cnt      <= 8'd0;
                        endgame      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl.
// Each task drives one scenario and checks against hand-computed values.
module tb_game_flow_ctrl;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       pause;
    logic [9:0] vector_y;
    logic       sec_tick;
    logic       hit_spike;
    logic       fell_off;
    logic       heal;
    logic [1:0] state;
    logic       frame_en;
    logic [2:0] scroll_speed;
    logic [2:0] lives;
    logic       invuln;
    logic       endgame;
    logic [1:0] sound_req;

    int tests  = 0;
    int failed = 0;

    game_flow_ctrl dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .start_btn    (start_btn),
        .pause        (pause),
        .vector_y     (vector_y),
        .sec_tick     (sec_tick),
        .hit_spike    (hit_spike),
        .fell_off     (fell_off),
        .heal         (heal),
        .state        (state),
        .frame_en     (frame_en),
        .scroll_speed (scroll_speed),
        .lives        (lives),
        .invuln       (invuln),
        .endgame      (endgame),
        .sound_req    (sound_req)
    );

    // 50 MHz clock
    always #10 clk_50m = ~clk_50m;

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic frame();
        vector_y = 10'd599;
        tick();
        vector_y = 10'd600;
        tick();
        vector_y = 10'd601;
        tick();
    endtask

    task automatic sec_pulse();
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        tick();
    endtask

    task automatic hit_pulse();
        hit_spike = 1'b1;
        tick();
        hit_spike = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (state !== 2'd0) begin failed++; $display("FAIL reset_state got=%0d want=0", state); end
        tests++; if (lives !== 3'd4) begin failed++; $display("FAIL reset_lives got=%0d want=4", lives); end
        tests++; if (scroll_speed !== 3'd1) begin failed++; $display("FAIL reset_speed got=%0d want=1", scroll_speed); end
        tests++; if ({invuln, endgame, frame_en} !== 3'b000) begin failed++; $display("FAIL reset_flags got=%b want=000", {invuln, endgame, frame_en}); end
        tests++; if (sound_req !== 2'd0) begin failed++; $display("FAIL reset_sound got=%0d want=0", sound_req); end
        rst = 1'b0;
        tick();
        tests++; if (state !== 2'd0) begin failed++; $display("FAIL idle_hold got=%0d want=0", state); end
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        tick();
        tests++; if (state !== 2'd1) begin failed++; $display("FAIL start_state got=%0d want=1", state); end
        tests++; if (lives !== 3'd4) begin failed++; $display("FAIL start_lives got=%0d want=4", lives); end
        tests++; if (scroll_speed !== 3'd1) begin failed++; $display("FAIL start_speed got=%0d want=1", scroll_speed); end
        tests++; if (endgame !== 1'b0) begin failed++; $display("FAIL start_endgame got=%0d want=0", endgame); end
    endtask

    task automatic test_frame();
        int pulses;
        int bad;
        pulses = 0;
        bad    = 0;
        for (int p = 0; p < 2; p++) begin
            for (int y = 0; y <= 665; y++) begin
                vector_y = 10'(y);
                tick();
                if (frame_en) pulses++;
                if (frame_en !== (y == 600)) bad++;
            end
        end
        tests++; if (pulses != 2) begin failed++; $display("FAIL frame_count got=%0d want=2", pulses); end
        tests++; if (bad != 0) begin failed++; $display("FAIL frame_align got=%0d bad cycles want=0", bad); end
        pause = 1'b1;
        tick();
        tests++; if (state !== 2'd2) begin failed++; $display("FAIL pause_state got=%0d want=2", state); end
        pulses = 0;
        for (int p = 0; p < 2; p++) begin
            for (int y = 0; y <= 665; y++) begin
                vector_y = 10'(y);
                tick();
                if (frame_en) pulses++;
            end
        end
        tests++; if (pulses != 0) begin failed++; $display("FAIL pause_frames got=%0d want=0", pulses); end
        tests++; if (state !== 2'd2) begin failed++; $display("FAIL pause_hold got=%0d want=2", state); end
        pause = 1'b0;
        tick();
        tests++; if (state !== 2'd1) begin failed++; $display("FAIL unpause_state got=%0d want=1", state); end
    endtask

    task automatic test_hit();
        hit_pulse();
        tests++; if (lives !== 3'd3) begin failed++; $display("FAIL hit_lives got=%0d want=3", lives); end
        tests++; if (sound_req !== 2'd1) begin failed++; $display("FAIL hit_sound got=%0d want=1", sound_req); end
        tests++; if (invuln !== 1'b1) begin failed++; $display("FAIL hit_invuln got=%0d want=1", invuln); end
        tick();
        tests++; if (sound_req !== 2'd0) begin failed++; $display("FAIL hit_sound_width got=%0d want=0", sound_req); end
        repeat (5) frame();
        hit_pulse();
        tests++; if (lives !== 3'd3) begin failed++; $display("FAIL hit_ignored_lives got=%0d want=3", lives); end
        tests++; if (sound_req !== 2'd0) begin failed++; $display("FAIL hit_ignored_sound got=%0d want=0", sound_req); end
        repeat (24) frame();
        tests++; if (invuln !== 1'b1) begin failed++; $display("FAIL invuln_29 got=%0d want=1", invuln); end
        frame();
        tests++; if (invuln !== 1'b0) begin failed++; $display("FAIL invuln_30 got=%0d want=0", invuln); end
    endtask

    task automatic test_hit_heal();
        hit_spike = 1'b1;
        heal      = 1'b1;
        tick();
        hit_spike = 1'b0;
        heal      = 1'b0;
        tests++; if (lives !== 3'd2) begin failed++; $display("FAIL hitheal_lives got=%0d want=2", lives); end
        tests++; if (sound_req !== 2'd1) begin failed++; $display("FAIL hitheal_sound got=%0d want=1", sound_req); end
        tick();
        heal = 1'b1;
        tick();
        heal = 1'b0;
        tests++; if ({lives, sound_req} !== {3'd3, 2'd2}) begin failed++; $display("FAIL heal1 got lives=%0d snd=%0d want 3/2", lives, sound_req); end
        tick();
        heal = 1'b1;
        tick();
        heal = 1'b0;
        tests++; if ({lives, sound_req} !== {3'd4, 2'd2}) begin failed++; $display("FAIL heal2 got lives=%0d snd=%0d want 4/2", lives, sound_req); end
        tick();
        heal = 1'b1;
        tick();
        heal = 1'b0;
        tests++; if ({lives, sound_req} !== {3'd4, 2'd0}) begin failed++; $display("FAIL heal_cap got lives=%0d snd=%0d want 4/0", lives, sound_req); end
    endtask

    task automatic test_speed();
        repeat (55) sec_pulse();
        tests++; if (scroll_speed !== 3'd6) begin failed++; $display("FAIL speed_55 got=%0d want=6", scroll_speed); end
        pause = 1'b1;
        tick();
        repeat (10) sec_pulse();
        pause = 1'b0;
        tick();
        tests++; if (state !== 2'd1) begin failed++; $display("FAIL speed_resume got=%0d want=1", state); end
        repeat (4) sec_pulse();
        tests++; if (scroll_speed !== 3'd6) begin failed++; $display("FAIL speed_59 got=%0d want=6", scroll_speed); end
        sec_pulse();
        tests++; if (scroll_speed !== 3'd7) begin failed++; $display("FAIL speed_60 got=%0d want=7", scroll_speed); end
        repeat (10) sec_pulse();
        tests++; if (scroll_speed !== 3'd7) begin failed++; $display("FAIL speed_cap got=%0d want=7", scroll_speed); end
    endtask

    task automatic test_over_fell();
        fell_off = 1'b1;
        pause    = 1'b1;
        tick();
        fell_off = 1'b0;
        pause    = 1'b0;
        tests++; if (state !== 2'd3) begin failed++; $display("FAIL fell_state got=%0d want=3", state); end
        tests++; if (lives !== 3'd0) begin failed++; $display("FAIL fell_lives got=%0d want=0", lives); end
        tests++; if (endgame !== 1'b1) begin failed++; $display("FAIL fell_endgame got=%0d want=1", endgame); end
        tests++; if (sound_req !== 2'd3) begin failed++; $display("FAIL fell_sound got=%0d want=3", sound_req); end
        tick();
        tests++; if ({state, sound_req} !== {2'd3, 2'd0}) begin failed++; $display("FAIL over_hold got st=%0d snd=%0d want 3/0", state, sound_req); end
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        tests++; if (state !== 2'd0) begin failed++; $display("FAIL restart_state got=%0d want=0", state); end
        tests++; if ({lives, scroll_speed, endgame} !== {3'd4, 3'd1, 1'b0}) begin failed++; $display("FAIL restart_init got lives=%0d spd=%0d eg=%0d want 4/1/0", lives, scroll_speed, endgame); end
        tick();
        tick();
        tests++; if (state !== 2'd0) begin failed++; $display("FAIL held_start got=%0d want=0", state); end
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        tests++; if (state !== 2'd1) begin failed++; $display("FAIL rerun_state got=%0d want=1", state); end
    endtask

    task automatic test_last_life();
        for (int i = 0; i < 3; i++) begin
            hit_pulse();
            repeat (30) frame();
        end
        tests++; if ({lives, invuln} !== {3'd1, 1'b0}) begin failed++; $display("FAIL last_life got lives=%0d inv=%0d want 1/0", lives, invuln); end
        hit_pulse();
        tests++; if ({state, lives} !== {2'd3, 3'd0}) begin failed++; $display("FAIL last_hit got st=%0d lives=%0d want 3/0", state, lives); end
        tests++; if ({endgame, sound_req} !== {1'b1, 2'd3}) begin failed++; $display("FAIL last_hit_out got eg=%0d snd=%0d want 1/3", endgame, sound_req); end
        tick();
        tests++; if (sound_req !== 2'd0) begin failed++; $display("FAIL last_snd_width got=%0d want=0", sound_req); end
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        tests++; if (state !== 2'd1) begin failed++; $display("FAIL last_rerun got=%0d want=1", state); end
    endtask

    task automatic test_reset_run();
        hit_pulse();
        repeat (10) sec_pulse();
        tests++; if ({lives, invuln, scroll_speed} !== {3'd3, 1'b1, 3'd2}) begin failed++; $display("FAIL prereset got lives=%0d inv=%0d spd=%0d want 3/1/2", lives, invuln, scroll_speed); end
        start_btn = 1'b0;
        rst       = 1'b1;
        tick();
        tests++; if ({state, lives, scroll_speed} !== {2'd0, 3'd4, 3'd1}) begin failed++; $display("FAIL runreset got st=%0d lives=%0d spd=%0d want 0/4/1", state, lives, scroll_speed); end
        tests++; if ({invuln, endgame, frame_en, sound_req} !== 5'b0) begin failed++; $display("FAIL runreset_flags got=%b want=00000", {invuln, endgame, frame_en, sound_req}); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        start_btn = 1'b0;
        pause     = 1'b0;
        vector_y  = 10'd0;
        sec_tick  = 1'b0;
        hit_spike = 1'b0;
        fell_off  = 1'b0;
        heal      = 1'b0;
        test_reset();
        test_start();
        test_frame();
        test_hit();
        test_hit_heal();
        test_speed();
        test_over_fell();
        test_last_life();
        test_reset_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Central game-flow sequencer for the 100-floors game. Owns the IDLE/RUN/PAUSED/OVER state machine, player lives and hit invulnerability, and difficulty (scroll speed) ramp. Issues one update strobe per video frame during vertical blank so the display and physics datapath advance only while the screen is not being drawn. Drives endgame to the score block and sound-event requests to the music block.

Parameters:
LIVES, 4, lives at game start and heal ceiling (1..7)
HIT_COOLDOWN, 30, frames of invulnerability after a spike hit (1..63)
VBLANK_LINE, 600, vector_y value marking the first blanking line
SPEED_STEP_SEC, 10, seconds of RUN time per speed increment (2..255)
MAX_SPEED, 7, scroll speed ceiling (1..7)

Ports:
clk_50m  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
start_btn  in  1  start/restart button level, already debounced and synchronous
pause  in  1  pause request level, high = pause
vector_y  in  10  current VGA scan line from the timing generator
sec_tick  in  1  one-cycle 1 Hz pulse, synchronous to clk_50m
hit_spike  in  1  one-cycle pulse: player touched a spike
fell_off  in  1  one-cycle pulse: player left screen top or bottom
heal  in  1  one-cycle pulse: player landed on a normal platform
state  out  2  0=IDLE 1=RUN 2=PAUSED 3=OVER
frame_en  out  1  one-cycle per-frame update strobe
scroll_speed  out  3  current difficulty level
lives  out  3  remaining lives
invuln  out  1  high while the hit cooldown is active
endgame  out  1  high in OVER
sound_req  out  2  one-cycle sound event: 1=hit, 2=heal, 3=game over, 0=none

Behaviour:
- Reset, synchronous, wins over all inputs: state=IDLE, lives=LIVES, scroll_speed=1, invuln=0, cooldown=0, sec_cnt=0, endgame=0, frame_en=0, sound_req=0, start and vector_y history registers cleared.
- start_rise = start_btn AND NOT start_btn_d (register start_btn_d).
- frame_en pulses for 1 cycle when vector_y==VBLANK_LINE and vy_d!=VBLANK_LINE and state==RUN. vy_d is vector_y delayed 1 cycle. Pulse occurs 0 cycles after the registered compare (output is registered, so it appears 1 cycle after the line change).
- IDLE: lives, speed, cooldown and sec_cnt held at their initial values. On start_rise go to RUN.
- RUN, events in priority order, evaluated in a single cycle:
  1) fell_off: lives=0, go to OVER, sound_req=3.
  2) pause high: go to PAUSED. The same-cycle hit and heal are dropped.
  3) hit_spike with invuln=0: if lives==1, lives=0, go to OVER, sound_req=3. Otherwise lives-1, cooldown=HIT_COOLDOWN, invuln=1, sound_req=1. hit_spike with invuln=1 is ignored.
  4) heal, when no hit is accepted this cycle: lives=min(lives+1,LIVES). sound_req=2 only if lives actually increased.
- Cooldown decrements on each frame_en. invuln=1 while cooldown!=0.
- sec_tick in RUN: if sec_cnt==SPEED_STEP_SEC-1, sec_cnt=0 and scroll_speed=min(scroll_speed+1,MAX_SPEED); otherwise sec_cnt+1.
- PAUSED: all counters frozen. No frame_en. sec_tick, hit, heal and fell_off are ignored. When pause goes low, return to RUN next cycle.
- OVER: endgame=1 (registered; 1 starting the cycle the state becomes OVER). All counters frozen. On start_rise go to IDLE and reinitialise as at reset, except the edge registers. A second start_rise is needed to enter RUN.
- sound_req is 0 in every cycle not listed above. It never holds for 2 cycles.
- start_btn held high across an OVER→IDLE transition does not re-trigger, because the start detect is edge-only.

Test Plan:
- Reset then start_btn 0→1: state 0→1 one cycle after the edge. lives=4, scroll_speed=1, endgame=0.
- RUN, sweep vector_y 0..665 twice: exactly 2 frame_en pulses, each 1 cycle wide, coinciding with line 600. Set pause=1 and repeat: zero pulses, state=2.
- RUN, hit_spike pulse: lives 4→3, sound_req=1 for 1 cycle, invuln=1. Second hit 5 frames later is ignored. invuln clears after the 30th frame_en.
- lives=3, hit_spike and heal in the same cycle: lives=2, sound_req=1. Later heal pulses at lives=4: lives stays 4, sound_req=0.
- RUN, 70 sec_tick pulses: scroll_speed reaches 7 at the 60th tick and stays at 7. Ticks during PAUSED do not advance sec_cnt.
- fell_off together with pause=1: state=3, lives=0, endgame=1, sound_req=3. start_rise → IDLE with lives=4 and endgame=0. Next start_rise → RUN. Asserting rst while in RUN returns all outputs to their reset values on the next edge.
